card_shoe_rng: RTL and testbench
================================

Name: card_shoe_rng

Overview:
- Parametrised successor to the free-running 1..10 card counter.
- An LFSR generates pseudo-random ranks 1..13, and rejection sampling keeps draws uniform.
- Ranks map to blackjack values (J/Q/K -> 10, ace -> 1).
- In shoe mode the block tracks per-rank depletion across NUM_DECKS decks and flags an empty shoe.
- The dealer/player FSMs request cards through a req/ready handshake.

Parameters:
- LFSR_W, 16: LFSR width. Legal values are 8, 16, 32; any other value is a synthesis error.
- SEED, 16'hACE1: reset value of the LFSR. Zero is replaced by 1.
- NUM_DECKS, 1: decks in the shoe, 1..8.
- SHOE_MODE, 1: 1 = track depletion; 0 = infinite deck, counts ignored, never empty.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seed_in  in  LFSR_W  reseed value
- seed_load  in  1  load seed_in into LFSR (zero -> 1)
- shuffle  in  1  refill shoe to full
- draw_req  in  1  request one card; accepted when draw_req & draw_ready
- draw_ready  out  1  block idle and able to accept a request
- card_valid  out  1  one-cycle pulse: result available
- card_rank  out  4  rank 1..13, held until next card_valid
- card_value  out  4  blackjack value 1..10, held until next card_valid
- draw_err  out  1  valid only with card_valid; 1 = shoe was empty, rank/value = 0
- shoe_empty  out  1  cards_left == 0 (SHOE_MODE=1 only)
- cards_left  out  CNT_W  remaining cards; CNT_W = clog2(52*NUM_DECKS+1)

Behaviour:
- Reset (async, rst=1):
  - LFSR = SEED (1 if SEED==0); state = IDLE.
  - All 13 rank counters = 4*NUM_DECKS; cards_left = 52*NUM_DECKS.
  - draw_ready=1, card_valid=0, card_rank=0, card_value=0, draw_err=0, shoe_empty=0.
- LFSR: Fibonacci XOR, shifts left, feedback into bit 0. Taps (1-indexed) are fixed per width:
  - 8: 8,6,5,4
  - 16: 16,15,13,4
  - 32: 32,22,2,1
  - The LFSR steps every cycle in all states (free-running entropy).
  - seed_load overrides the step that cycle.
- States: IDLE, DRAW, SHUF.
- IDLE:
  - draw_ready=1.
  - shuffle=1 -> SHUF. shuffle has priority over draw_req; the request is not accepted that cycle.
  - Otherwise, an accepted draw_req with SHOE_MODE=1 and cards_left==0 -> next cycle card_valid=1, draw_err=1, rank/value=0; stay IDLE.
  - Otherwise, an accepted draw_req -> DRAW.
- DRAW (draw_ready=0):
  - Each cycle, candidate = LFSR[3:0].
  - Accept the candidate if it is in 1..13 and (SHOE_MODE=0 or count[candidate]>0).
  - On accept:
    - Register card_rank = candidate and card_value = min(candidate,10).
    - Pulse card_valid for one cycle, draw_err=0.
    - In shoe mode, decrement count[candidate] and cards_left.
    - Return to IDLE.
  - On reject: stay in DRAW.
  - Latency from acceptance to card_valid is >=1 cycle.
  - Maximal-length LFSR guarantees every 4-bit pattern appears within one period, so the draw terminates.
- SHUF (one cycle, draw_ready=0):
  - Reload all counters and cards_left to full; shoe_empty=0.
  - Return to IDLE.
  - shuffle asserted in DRAW is ignored.
- shoe_empty:
  - Combinational from cards_left==0 when SHOE_MODE=1; constant 0 when SHOE_MODE=0.
  - cards_left stays 52*NUM_DECKS when SHOE_MODE=0.
- draw_req held high: one card per IDLE visit. Back-to-back requests give at most one card every 2 cycles.
- Reset mid-DRAW: pending draw is discarded, no card_valid, counters full.
- Counters never underflow; a draw from an empty shoe never decrements.

Test Plan:
- Reset, release, observe 3 cycles -> draw_ready=1, card_valid=0, cards_left=52 (NUM_DECKS=1), shoe_empty=0, LFSR after reset = 16'hACE1.
- SHOE_MODE=1, NUM_DECKS=1, 52 consecutive draws -> 52 card_valid pulses with draw_err=0; each rank 1..13 seen exactly 4 times; card_value = 10 for ranks 10..13; cards_left counts 52->0; shoe_empty=1 after the last draw.
- 53rd draw on empty shoe -> card_valid=1, draw_err=1, rank=value=0, cards_left stays 0. Then shuffle -> after 1 cycle cards_left=52, shoe_empty=0.
- seed_load with seed_in=0 -> LFSR=1. Repeat an identical seed_load + draw sequence twice -> identical card_rank streams.
- SHOE_MODE=0: 1000 draws -> never draw_err; shoe_empty=0; cards_left=52; all ranks within 1..13; values within 1..10.
- shuffle and draw_req in the same IDLE cycle -> SHUF taken, no card that cycle. rst=1 mid-DRAW -> no card_valid; all outputs at reset values.

Source files
------------

// File: rtl/card_shoe_rng.sv
// Card source for the blackjack table: LFSR-driven rank draws with rejection
// sampling, blackjack value mapping and optional multi-deck shoe depletion.
module card_shoe_rng #(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned       NUM_DECKS = 1,
    parameter bit                SHOE_MODE = 1'b1,
    localparam int unsigned      CNT_W     = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              seed_load,
    input  logic              shuffle,
    input  logic              draw_req,
    output logic              draw_ready,
    output logic              card_valid,
    output logic [3:0]        card_rank,
    output logic [3:0]        card_value,
    output logic              draw_err,
    output logic              shoe_empty,
    output logic [CNT_W-1:0]  cards_left
);

    localparam int unsigned       RCNT_W    = $clog2(4 * NUM_DECKS + 1);
    localparam logic [RCNT_W-1:0] RANK_FULL = RCNT_W'(4 * NUM_DECKS);
    localparam logic [CNT_W-1:0]  SHOE_FULL = CNT_W'(52 * NUM_DECKS);
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? LFSR_W'(1) : SEED;

    typedef enum logic [1:0] {IDLE, DRAW, SHUF} state_t;

    state_t              state, state_nx;
    logic [LFSR_W-1:0]   lfsr, lfsr_step;
    logic                fb;
    logic [RCNT_W-1:0]   cnt    [16];
    logic [RCNT_W-1:0]   cnt_nx [16];
    logic [CNT_W-1:0]    left_nx;
    logic                valid_nx, err_nx;
    logic [3:0]          rank_nx, value_nx;
    logic [3:0]          cand;
    logic                cand_ok;

    // Full-shoe count per rank slot; slots 0, 14 and 15 stay empty so they never accept.
    function automatic logic [RCNT_W-1:0] full_cnt(input int unsigned idx);
        return (idx >= 1 && idx <= 13) ? RANK_FULL : '0;
    endfunction

    if (NUM_DECKS < 1 || NUM_DECKS > 8) begin : g_bad_decks
        $error("card_shoe_rng: NUM_DECKS must be 1..8");
    end

    // Feedback taps per supported width (maximal-length polynomials).
    if (LFSR_W == 8) begin : g_tap8
        assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (LFSR_W == 16) begin : g_tap16
        assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
    end else if (LFSR_W == 32) begin : g_tap32
        assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_bad_w
        assign fb = 1'b0;
        $error("card_shoe_rng: LFSR_W must be 8, 16 or 32");
    end

    assign lfsr_step = {lfsr[LFSR_W-2:0], fb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else if (seed_load) begin
            lfsr <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
        end else begin
            lfsr <= lfsr_step;
        end
    end

    assign cand       = lfsr[3:0];
    assign cand_ok    = (cand >= 4'd1) && (cand <= 4'd13) && (!SHOE_MODE || (cnt[cand] != '0));
    assign shoe_empty = SHOE_MODE ? (cards_left == '0) : 1'b0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        left_nx  = cards_left;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        rank_nx  = card_rank;
        value_nx = card_value;
        unique case (state)
            IDLE: begin
                if (shuffle) begin
                    state_nx = SHUF;
                end else if (draw_req) begin
                    if (SHOE_MODE && (cards_left == '0)) begin
                        valid_nx = 1'b1;
                        err_nx   = 1'b1;
                        rank_nx  = 4'd0;
                        value_nx = 4'd0;
                    end else begin
                        state_nx = DRAW;
                    end
                end
            end
            DRAW: begin
                // Out-of-range or depleted candidates are rejected; retry on the next LFSR step.
                if (cand_ok) begin
                    valid_nx = 1'b1;
                    rank_nx  = cand;
                    value_nx = (cand > 4'd10) ? 4'd10 : cand;
                    if (SHOE_MODE) begin
                        cnt_nx[cand] = cnt[cand] - RCNT_W'(1);
                        left_nx      = cards_left - CNT_W'(1);
                    end
                    state_nx = IDLE;
                end
            end
            SHUF: begin
                for (int i = 0; i < 16; i++) begin
                    cnt_nx[i] = full_cnt(i);
                end
                left_nx  = SHOE_FULL;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            draw_ready <= 1'b1;
            card_valid <= 1'b0;
            draw_err   <= 1'b0;
            card_rank  <= 4'd0;
            card_value <= 4'd0;
            cards_left <= SHOE_FULL;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= full_cnt(i);
            end
        end else begin
            state      <= state_nx;
            draw_ready <= (state_nx == IDLE);
            card_valid <= valid_nx;
            draw_err   <= err_nx;
            card_rank  <= rank_nx;
            card_value <= value_nx;
            cards_left <= left_nx;
            cnt        <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_card_shoe_rng.sv
// Directed bench for card_shoe_rng: one shoe-mode instance and one
// infinite-deck instance sharing clock and reset.
module tb_card_shoe_rng;

    localparam int unsigned CNT_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0]      seed_in0, seed_in1;
    logic             seed_load0, seed_load1, shuffle0, shuffle1, req0, req1;
    logic             ready0, ready1, valid0, valid1, err0, err1, empty0, empty1;
    logic [3:0]       rank0, rank1, value0, value1;
    logic [CNT_W-1:0] left0, left1;

    card_shoe_rng #(.LFSR_W(16), .SEED(16'hACE1), .NUM_DECKS(1), .SHOE_MODE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .seed_in(seed_in0), .seed_load(seed_load0),
        .shuffle(shuffle0), .draw_req(req0), .draw_ready(ready0),
        .card_valid(valid0), .card_rank(rank0), .card_value(value0),
        .draw_err(err0), .shoe_empty(empty0), .cards_left(left0)
    );

    card_shoe_rng #(.LFSR_W(16), .SEED(16'hACE1), .NUM_DECKS(1), .SHOE_MODE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .seed_in(seed_in1), .seed_load(seed_load1),
        .shuffle(shuffle1), .draw_req(req1), .draw_ready(ready1),
        .card_valid(valid1), .card_rank(rank1), .card_value(value1),
        .draw_err(err1), .shoe_empty(empty1), .cards_left(left1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One draw on the shoe instance, optionally reseeding in the request cycle.
    task automatic draw0(input logic ld, input logic [15:0] s,
                         output logic [3:0] r, output logic [3:0] v, output logic e, output int lat);
        int n = 0;
        while (!ready0 && n < 50) begin @(negedge clk); n++; end
        seed_in0 = s; seed_load0 = ld; req0 = 1'b1;
        @(negedge clk);
        seed_load0 = 1'b0; req0 = 1'b0;
        lat = 1;
        while (!valid0 && lat < 4000) begin @(negedge clk); lat++; end
        if (!valid0) check("draw0_timeout", 32'(valid0), 32'd1);
        r = rank0; v = value0; e = err0;
    endtask

    task automatic draw1(output logic [3:0] r, output logic [3:0] v, output logic e);
        int n = 0;
        while (!ready1 && n < 50) begin @(negedge clk); n++; end
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        n = 1;
        while (!valid1 && n < 4000) begin @(negedge clk); n++; end
        if (!valid1) check("draw1_timeout", 32'(valid1), 32'd1);
        r = rank1; v = value1; e = err1;
    endtask

    task automatic do_shuffle0();
        shuffle0 = 1'b1;
        @(negedge clk);
        shuffle0 = 1'b0;
        @(negedge clk);
    endtask

    logic [3:0]  r, v;
    logic        e;
    int          lat;
    int          hist [14];
    int          bad_rank, bad_val, bad_err, bad_left, bad_empty, mism;
    logic [3:0]  run [2][8];
    logic [15:0] vec_seed [4] = '{16'h0007, 16'h000E, 16'h0000, 16'h000C};
    logic [3:0]  vec_rank [4] = '{4'd7, 4'd13, 4'd1, 4'd12};
    logic [3:0]  vec_val  [4] = '{4'd7, 4'd10, 4'd1, 4'd10};
    int          vec_lat  [4] = '{2, 3, 2, 2};

    initial begin
        rst = 1'b1;
        seed_in0 = '0; seed_load0 = 1'b0; shuffle0 = 1'b0; req0 = 1'b0;
        seed_in1 = '0; seed_load1 = 1'b0; shuffle1 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("lfsr_reset", 32'(dut0.lfsr), 32'hACE1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_left", 32'(left0), 32'd52);
        check("rst_empty", 32'(empty0), 32'd0);
        check("rst_rank_value_err", {23'd0, rank0, value0, err0}, 32'd0);

        // Deplete a full deck.
        for (int k = 0; k < 14; k++) hist[k] = 0;
        bad_rank = 0; bad_val = 0; bad_err = 0; bad_left = 0;
        for (int i = 0; i < 52; i++) begin
            draw0(1'b0, 16'h0, r, v, e, lat);
            if (r < 4'd1 || r > 4'd13) bad_rank++; else hist[r]++;
            if (v != ((r > 4'd10) ? 4'd10 : r)) bad_val++;
            if (e) bad_err++;
            if (left0 != CNT_W'(51 - i)) bad_left++;
        end
        for (int k = 1; k <= 13; k++) check($sformatf("rank%0d_count", k), 32'(hist[k]), 32'd4);
        check("deck_bad_rank", 32'(bad_rank), 32'd0);
        check("deck_bad_value", 32'(bad_val), 32'd0);
        check("deck_draw_err", 32'(bad_err), 32'd0);
        check("deck_left_seq", 32'(bad_left), 32'd0);
        check("deck_left_end", 32'(left0), 32'd0);
        check("deck_empty", 32'(empty0), 32'd1);

        // Draw from the empty shoe.
        draw0(1'b0, 16'h0, r, v, e, lat);
        check("empty_lat", 32'(lat), 32'd1);
        check("empty_err", 32'(e), 32'd1);
        check("empty_rank", 32'(r), 32'd0);
        check("empty_value", 32'(v), 32'd0);
        check("empty_left", 32'(left0), 32'd0);

        shuffle0 = 1'b1;
        @(negedge clk);
        shuffle0 = 1'b0;
        check("shuf_busy", 32'(ready0), 32'd0);
        @(negedge clk);
        check("shuf_left", 32'(left0), 32'd52);
        check("shuf_empty", 32'(empty0), 32'd0);
        check("shuf_ready", 32'(ready0), 32'd1);

        // Zero seed is forced to 1.
        seed_in0 = 16'h0000; seed_load0 = 1'b1;
        @(negedge clk);
        seed_load0 = 1'b0;
        check("seed_zero", 32'(dut0.lfsr), 32'd1);

        // Reseed in the request cycle: the first candidate is the seed's low nibble.
        for (int i = 0; i < 4; i++) begin
            draw0(1'b1, vec_seed[i], r, v, e, lat);
            check($sformatf("seed%0h_rank", vec_seed[i]), 32'(r), 32'(vec_rank[i]));
            check($sformatf("seed%0h_value", vec_seed[i]), 32'(v), 32'(vec_val[i]));
            check($sformatf("seed%0h_lat", vec_seed[i]), 32'(lat), 32'(vec_lat[i]));
        end
        check("seeded_left", 32'(left0), 32'd48);

        // shuffle wins over draw_req in the same IDLE cycle.
        shuffle0 = 1'b1; req0 = 1'b1;
        @(negedge clk);
        shuffle0 = 1'b0; req0 = 1'b0;
        check("shufreq_valid", 32'(valid0), 32'd0);
        check("shufreq_busy", 32'(ready0), 32'd0);
        @(negedge clk);
        check("shufreq_valid2", 32'(valid0), 32'd0);
        check("shufreq_left", 32'(left0), 32'd52);

        // Identical reseed and draw sequences give identical streams.
        for (int p = 0; p < 2; p++) begin
            do_shuffle0();
            seed_in0 = 16'h1234; seed_load0 = 1'b1;
            @(negedge clk);
            seed_load0 = 1'b0;
            for (int k = 0; k < 8; k++) begin
                draw0(1'b0, 16'h0, r, v, e, lat);
                run[p][k] = r;
            end
        end
        mism = 0;
        for (int k = 0; k < 8; k++) if (run[0][k] != run[1][k]) mism++;
        check("seed_repeat", 32'(mism), 32'd0);

        // Reset in the middle of a long rejection run.
        do_shuffle0();
        draw0(1'b0, 16'h0, r, v, e, lat);
        check("pre_rst_left", 32'(left0), 32'd51);
        draw0(1'b0, 16'h0, r, v, e, lat);
        seed_in0 = 16'h000F; seed_load0 = 1'b1; req0 = 1'b1;
        @(negedge clk);
        seed_load0 = 1'b0; req0 = 1'b0;
        check("middraw_busy", 32'(ready0), 32'd0);
        bad_val = 0;
        repeat (2) begin
            if (valid0) bad_val++;
            @(negedge clk);
        end
        check("middraw_no_valid", 32'(bad_val), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(valid0), 32'd0);
        check("midrst_ready", 32'(ready0), 32'd1);
        check("midrst_rank_value_err", {23'd0, rank0, value0, err0}, 32'd0);
        check("midrst_left", 32'(left0), 32'd52);
        check("midrst_empty", 32'(empty0), 32'd0);
        check("midrst_lfsr", 32'(dut0.lfsr), 32'hACE1);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_valid", 32'(valid0), 32'd0);

        // Infinite deck: never empties, never errors.
        bad_rank = 0; bad_val = 0; bad_err = 0; bad_left = 0; bad_empty = 0;
        for (int i = 0; i < 1000; i++) begin
            draw1(r, v, e);
            if (r < 4'd1 || r > 4'd13) bad_rank++;
            if (v < 4'd1 || v > 4'd10 || v != ((r > 4'd10) ? 4'd10 : r)) bad_val++;
            if (e) bad_err++;
            if (left1 != CNT_W'(52)) bad_left++;
            if (empty1) bad_empty++;
        end
        check("inf_bad_rank", 32'(bad_rank), 32'd0);
        check("inf_bad_value", 32'(bad_val), 32'd0);
        check("inf_draw_err", 32'(bad_err), 32'd0);
        check("inf_left", 32'(bad_left), 32'd0);
        check("inf_empty", 32'(bad_empty), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
